// File: rtl/ndp_reduce_accel.sv
// ---------------------------------------------------------------------------
// ndp_reduce_accel
//
// Streaming lane-wise reduction engine for the near-data accelerator path.
// A start command programs a word count and a reduction mode. The engine then
// consumes that many DATA_W-bit words over a valid/ready stream. Each word is
// split into LANES lanes of LANE_W bits. The lanes are first reduced inside
// the word, and the per-word value is then folded into an ACC_W-bit
// accumulator.
//
// Modes (mode_i):
//   00 usum  unsigned sum of all lanes, wraps modulo 2^ACC_W
//   01 ssum  signed (two's complement) sum of all lanes, wraps modulo 2^ACC_W
//   10 umax  unsigned maximum lane value
//   11 umin  unsigned minimum lane value
//
// Input handshake: a word transfers on a rising clk_i edge where in_valid_i
// and in_ready_o are both high. in_ready_o depends only on the engine state,
// never on in_valid_i, so the producer may hold a word for as long as it likes.
//
// Ports:
//   clk_i       clock
//   arst_i      asynchronous, active-high reset; aborts any job silently
//   start_i     level start request, sampled only while idle
//   len_i       number of words in the job, sampled with start_i
//   mode_i      reduction mode, sampled with start_i
//   in_valid_i  input word valid
//   in_data_i   input word; lane k = in_data_i[(k+1)*LANE_W-1 : k*LANE_W]
//   in_ready_o  engine accepts a word this cycle (state ACCUM)
//   busy_o      job in progress or result pending (state ACCUM or DONE)
//   result_o    reduction result, stable while done_o is high
//   ovf_o       sticky overflow of the current/last job (sum modes only)
//   done_o      result valid; held until start_i is released
// ---------------------------------------------------------------------------
module ndp_reduce_accel #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int LANE_W = DATA_W / LANES,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [1:0]        mode_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              busy_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              ovf_o,
    output logic              done_o
);

    // Width of an in-word lane sum; large enough that LANES lanes never
    // overflow it, in either signed or unsigned interpretation.
    localparam int SUM_W = LANE_W + $clog2(LANES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_USUM = 2'd0;
    localparam logic [1:0] M_SSUM = 2'd1;
    localparam logic [1:0] M_UMAX = 2'd2;
    localparam logic [1:0] M_UMIN = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;
    logic             r_ovf;
    logic             r_done;

    logic [SUM_W-1:0] w_usum;
    logic [SUM_W-1:0] w_ssum;
    logic [LANE_W-1:0] w_lmax;
    logic [LANE_W-1:0] w_lmin;
    logic [ACC_W-1:0] w_ssum_ext;
    logic [ACC_W-1:0] w_beat_val;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_lmax_ext;
    logic [ACC_W-1:0] w_lmin_ext;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_beat;
    logic             w_fire;
    logic             w_last;

    // ------------------------------------------------------------------
    // In-word lane reduction (all four flavours computed in parallel)
    // ------------------------------------------------------------------
    always_comb begin
        w_usum = '0;
        w_ssum = '0;
        w_lmax = '0;
        w_lmin = '1;
        for (int k = 0; k < LANES; k++) begin
            w_usum = w_usum + SUM_W'(in_data_i[k*LANE_W +: LANE_W]);
            w_ssum = w_ssum + SUM_W'($signed(in_data_i[k*LANE_W +: LANE_W]));
            if (in_data_i[k*LANE_W +: LANE_W] > w_lmax) begin
                w_lmax = in_data_i[k*LANE_W +: LANE_W];
            end
            if (in_data_i[k*LANE_W +: LANE_W] < w_lmin) begin
                w_lmin = in_data_i[k*LANE_W +: LANE_W];
            end
        end
    end

    // Sign-extend the signed lane sum to the accumulator width.
    assign w_ssum_ext = ACC_W'($signed(w_ssum));
    assign w_beat_val = (r_mode == M_SSUM) ? w_ssum_ext : ACC_W'(w_usum);
    assign w_lmax_ext = ACC_W'(w_lmax);
    assign w_lmin_ext = ACC_W'(w_lmin);

    // One extra bit captures the unsigned carry out of the accumulator.
    assign w_add = {1'b0, r_acc} + {1'b0, w_beat_val};

    always_comb begin
        w_acc_next = r_acc;
        w_ovf_beat = 1'b0;
        case (r_mode)
            M_USUM: begin
                w_acc_next = w_add[ACC_W-1:0];
                w_ovf_beat = w_add[ACC_W];
            end
            M_SSUM: begin
                w_acc_next = w_add[ACC_W-1:0];
                // Signed overflow: both operands share a sign that the
                // wrapped result does not.
                w_ovf_beat = (r_acc[ACC_W-1] == w_beat_val[ACC_W-1]) &&
                             (w_add[ACC_W-1] != r_acc[ACC_W-1]);
            end
            M_UMAX: begin
                w_acc_next = (w_lmax_ext > r_acc) ? w_lmax_ext : r_acc;
            end
            M_UMIN: begin
                w_acc_next = (w_lmin_ext < r_acc) ? w_lmin_ext : r_acc;
            end
            default: begin
                w_acc_next = r_acc;
            end
        endcase
    end

    assign w_fire = in_valid_i && (r_state == S_ACCUM);
    assign w_last = (r_cnt == CNT_W'(1));

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= S_IDLE;
            r_mode   <= M_USUM;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ovf <= 1'b0;
                        if (len_i != '0) begin
                            r_mode  <= mode_i;
                            r_cnt   <= len_i;
                            // umin starts from the largest lane value so the
                            // first word always wins the compare.
                            r_acc   <= (mode_i == M_UMIN) ? ACC_W'({LANE_W{1'b1}}) : '0;
                            r_state <= S_ACCUM;
                        end else begin
                            // Empty job: report a zero result straight away.
                            r_result <= '0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_fire) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_ovf_beat) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_last) begin
                            r_result <= w_acc_next;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A start held high across DONE must drop before the
                    // engine can accept another job.
                    if (!start_i) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o = (r_state == S_ACCUM);
    assign busy_o     = (r_state != S_IDLE);
    assign result_o   = r_result;
    assign ovf_o      = r_ovf;
    assign done_o     = r_done;

endmodule

// File: tb/tb_ndp_reduce_accel.sv
// ---------------------------------------------------------------------------
// tb_ndp_reduce_accel
//
// Drives two copies of the engine from one stimulus stream: the default
// configuration (ACC_W=32) and a narrow accumulator (ACC_W=10) that makes
// wrap and overflow easy to reach. Expected results come from a lane-level
// arithmetic model and are queued in a scoreboard; each job's result is
// popped and compared when done_o is due.
// ---------------------------------------------------------------------------
module tb_ndp_reduce_accel;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic arst_i;
  always #5 clk = ~clk;

  // stimulus
  logic              start_i;
  logic [CNT_W-1:0]  len_i;
  logic [1:0]        mode_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;

  // observed, 32-bit accumulator copy
  logic        rdy32, busy32, ovf32, done32;
  logic [31:0] res32;
  // observed, 10-bit accumulator copy
  logic        rdy10, busy10, ovf10, done10;
  logic [9:0]  res10;

  ndp_reduce_accel #(.DATA_W(32), .LANES(4), .ACC_W(32), .CNT_W(16)) dut (
    .clk_i      (clk),
    .arst_i     (arst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .mode_i     (mode_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (rdy32),
    .busy_o     (busy32),
    .result_o   (res32),
    .ovf_o      (ovf32),
    .done_o     (done32)
  );

  ndp_reduce_accel #(.DATA_W(32), .LANES(4), .ACC_W(10), .CNT_W(16)) dut10 (
    .clk_i      (clk),
    .arst_i     (arst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .mode_i     (mode_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (rdy10),
    .busy_o     (busy10),
    .result_o   (res10),
    .ovf_o      (ovf10),
    .done_o     (done10)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp10_q[$];
  logic        exp_ovf_q[$];
  logic        exp_ovf10_q[$];
  logic [31:0] job_words[16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: reduces job_words[0..len-1] with a w-bit accumulator.
  task automatic model(input logic [1:0] mode, input int len, input int w,
                       output logic [31:0] res, output logic ovf);
    longint mask, hi, lo, total, acc, s;
    int     lane, m;
    logic   ovf_s;
    mask  = (longint'(1) << w) - 1;
    hi    = (longint'(1) << (w - 1)) - 1;
    lo    = -hi - 1;
    total = 0;
    acc   = 0;
    ovf_s = 1'b0;
    m     = (mode == 2'd3) ? 255 : 0;
    for (int i = 0; i < len; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        lane  = int'((job_words[i] >> (8 * k)) & 32'hFF);
        total += lane;
        s     += (lane > 127) ? lane - 256 : lane;
        if (lane > m && mode == 2'd2) m = lane;
        if (lane < m && mode == 2'd3) m = lane;
      end
      acc += s;
      if (acc < lo || acc > hi) ovf_s = 1'b1;
      acc = acc & mask;
      if (acc > hi) acc -= (mask + 1);
    end
    case (mode)
      2'd0: begin res = 32'(total & mask); ovf = (total > mask); end
      2'd1: begin res = 32'(acc & mask);   ovf = ovf_s;          end
      default: begin res = 32'(m);         ovf = 1'b0;           end
    endcase
    if (len == 0) begin
      res = 32'd0;
      ovf = 1'b0;
    end
  endtask

  // Driver: one complete job. gap < 0 gives random idle cycles before each
  // word; otherwise exactly gap idle cycles between consecutive words.
  task automatic run_job(input logic [1:0] mode, input int len, input int gap);
    logic [31:0] e32, e10;
    logic        o32, o10;
    int          g;
    model(mode, len, 32, e32, o32);
    model(mode, len, 10, e10, o10);
    exp_q.push_back(e32);
    exp10_q.push_back(e10);
    exp_ovf_q.push_back(o32);
    exp_ovf10_q.push_back(o10);

    @(negedge clk);
    start_i    = 1'b1;
    len_i      = CNT_W'(len);
    mode_i     = mode;
    in_valid_i = 1'b0;
    @(negedge clk);

    if (len == 0) begin
      for (int c = 0; c < 2 && !done32; c++) begin
        check("len0_rdy", rdy32, 0);
        @(negedge clk);
      end
      check("len0_rdy_done", rdy32, 0);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (gap < 0) g = $urandom_range(0, 2);
        else         g = (i == 0) ? 0 : gap;
        for (int j = 0; j < g; j++) begin
          // Garbage on the data/command inputs must be ignored while busy.
          in_valid_i = 1'b0;
          in_data_i  = $urandom;
          len_i      = CNT_W'($urandom);
          mode_i     = 2'($urandom);
          check("gap_rdy", rdy32, 1);
          check("gap_done", done32, 0);
          @(negedge clk);
        end
        in_valid_i = 1'b1;
        in_data_i  = job_words[i];
        check("beat_rdy", rdy32, 1);
        check("beat_done", done32, 0);
        @(negedge clk);
      end
      in_valid_i = 1'b0;
    end

    check("done32", done32, 1);
    check("done10", done10, 1);
    check("done_busy", busy32, 1);
    check("done_rdy", rdy32, 0);
    check("res32", res32, exp_q.pop_front());
    check("ovf32", ovf32, exp_ovf_q.pop_front());
    check("res10", res10, exp10_q.pop_front());
    check("ovf10", ovf10, exp_ovf10_q.pop_front());

    // start still high: no retrigger, extra words ignored
    for (int c = 0; c < 2; c++) begin
      in_valid_i = 1'b1;
      in_data_i  = $urandom;
      @(negedge clk);
      check("hold_done", done32, 1);
      check("hold_rdy", rdy32, 0);
      check("hold_res", res32, e32);
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("drop_done", done32, 0);
    check("drop_busy", busy32, 0);
    check("keep_res", res32, e32);
    check("keep_ovf", ovf32, o32);
    check("keep_res10", res10, e10[9:0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arst_i     = 1'b1;
    start_i    = 1'b0;
    len_i      = '0;
    mode_i     = 2'd0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy32, 0);
    check("rst_busy", busy32, 0);
    check("rst_res", res32, 0);
    check("rst_ovf", ovf32, 0);
    check("rst_done", done32, 0);
    arst_i = 1'b0;
    @(negedge clk);

    // directed jobs
    job_words[0] = 32'h04030201;
    run_job(2'd0, 1, 0);                          // 10
    job_words[1] = 32'hFFFFFFFF;
    run_job(2'd0, 2, 3);                          // 1030, 10-bit wraps
    job_words[0] = 32'hFFFFFFFF;
    run_job(2'd0, 2, 0);                          // 2040 / 1016 with ovf
    job_words[0] = 32'h00000000;
    run_job(2'd0, 1, 0);                          // ovf cleared, 0
    job_words[0] = 32'h0001FFFF;
    run_job(2'd1, 1, 0);                          // -1
    job_words[0] = 32'h10FF0580;
    run_job(2'd2, 1, 0);                          // 0xFF
    job_words[0] = 32'h10203040;
    job_words[1] = 32'h05060708;
    run_job(2'd3, 2, 1);                          // 0x05

    // reset in the middle of a job
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 16'd3;
    mode_i  = 2'd0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = 32'h11223344;
    @(negedge clk);
    in_valid_i = 1'b0;
    arst_i     = 1'b1;
    #1;
    check("arst_rdy", rdy32, 0);
    check("arst_busy", busy32, 0);
    check("arst_res", res32, 0);
    check("arst_ovf", ovf32, 0);
    check("arst_done", done32, 0);
    check("arst_res10", res10, 0);
    start_i = 1'b0;
    @(negedge clk);
    arst_i = 1'b0;
    job_words[0] = 32'h01010101;
    run_job(2'd0, 1, 0);                          // 4, no residue

    job_words[0] = 32'h80808080;
    job_words[1] = 32'h80808080;
    run_job(2'd1, 2, 0);                          // signed overflow in 10-bit
    run_job(2'd2, 0, 0);                          // empty job

    // randomized jobs
    for (int j = 0; j < 24; j++) begin
      int          rlen;
      logic [1:0]  rmode;
      rlen  = $urandom_range(0, 6);
      rmode = 2'($urandom_range(0, 3));
      for (int i = 0; i < rlen; i++) begin
        case ($urandom_range(0, 3))
          0:       job_words[i] = 32'hFFFFFFFF;
          1:       job_words[i] = 32'h80808080;
          default: job_words[i] = $urandom;
        endcase
      end
      run_job(rmode, rlen, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
